// File: rtl/mem_responder.sv
// Byte-serial memory responder: turns data-port and fetch requests into
// little-endian 8-bit RAM accesses and returns one completion pulse each.
module mem_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rst_c,
  input  logic              en_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [2:0]        width_i,
  output logic              rdy_o,
  output logic [31:0]       data_o,
  input  logic              if_en_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_rdy_o,
  output logic [31:0]       if_data_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, n_q, n_d;
  logic              src_q, src_d;      // 1 = fetch transaction
  logic [31:0]       data_q, data_d;    // store bytes still to send, LSB next
  logic [31:0]       res_q, res_d;      // load bytes assembled so far
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              rdy_o_q, rdy_o_d, if_rdy_o_q, if_rdy_o_d;
  logic [31:0]       data_o_q, data_o_d, if_data_o_q, if_data_o_d;

  logic       acc_data, acc_fetch, acc_rw;
  logic [2:0] acc_n, cnt_inc;
  logic [1:0] rd_idx;

  assign acc_data  = en_i;
  assign acc_fetch = !en_i && if_en_i && !rst_c;
  assign acc_n     = acc_data ? ((width_i > 3'd4) ? 3'd4 : width_i) : 3'd4;
  assign acc_rw    = acc_data ? rw_i : 1'b1;
  assign cnt_inc   = cnt_q + 3'd1;
  // In RD, cnt counts addresses issued; mem_din carries the byte before it.
  assign rd_idx    = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    src_d       = src_q;
    data_d      = data_q;
    res_d       = res_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    rdy_o_d     = rdy_o_q;
    if_rdy_o_d  = if_rdy_o_q;
    data_o_d    = data_o_q;
    if_data_o_d = if_data_o_q;
    if (rdy) begin
      mem_wr_d   = 1'b0;
      rdy_o_d    = 1'b0;
      if_rdy_o_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acc_data || acc_fetch) begin
            src_d  = acc_fetch;
            n_d    = acc_n;
            cnt_d  = 3'd0;
            res_d  = 32'h0;
            data_d = {8'h00, data_i[31:8]};
            if (acc_n == 3'd0) begin
              state_d  = DONE;
              rdy_o_d  = 1'b1;
              data_o_d = 32'h0;
            end else begin
              mem_a_d = acc_data ? addr_i : if_addr_i;
              if (acc_rw) begin
                state_d = RD;
              end else begin
                state_d    = WR;
                mem_wr_d   = 1'b1;
                mem_dout_d = data_i[7:0];
              end
            end
          end
        end
        WR: begin
          if (cnt_inc < n_q) begin
            cnt_d      = cnt_inc;
            mem_a_d    = mem_a_q + ADDR_ONE;
            mem_dout_d = data_q[7:0];
            data_d     = {8'h00, data_q[31:8]};
            mem_wr_d   = 1'b1;
          end else begin
            state_d  = DONE;
            rdy_o_d  = 1'b1;
            data_o_d = 32'h0;
          end
        end
        RD: begin
          // A flush drops a fetch outright; data loads never see it.
          if (src_q && rst_c) begin
            state_d = IDLE;
          end else begin
            if (cnt_q != 3'd0) res_d[{rd_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q == n_q) begin
              state_d = DONE;
              if (src_q) begin
                if_rdy_o_d  = 1'b1;
                if_data_o_d = res_d;
              end else begin
                rdy_o_d  = 1'b1;
                data_o_d = res_d;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc < n_q) mem_a_d = mem_a_q + ADDR_ONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      src_q       <= 1'b0;
      data_q      <= '0;
      res_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      rdy_o_q     <= 1'b0;
      if_rdy_o_q  <= 1'b0;
      data_o_q    <= '0;
      if_data_o_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      src_q       <= src_d;
      data_q      <= data_d;
      res_q       <= res_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      rdy_o_q     <= rdy_o_d;
      if_rdy_o_q  <= if_rdy_o_d;
      data_o_q    <= data_o_d;
      if_data_o_q <= if_data_o_d;
    end
  end

  assign rdy_o     = rdy_o_q;
  assign data_o    = data_o_q;
  assign if_rdy_o  = if_rdy_o_q;
  assign if_data_o = if_data_o_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a small RAM model on the byte bus, expected
// bus writes and completions queued at stimulus time and popped as they appear.
module tb_mem_responder;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic        chk;
    logic [31:0] d;
  } dexp_t;

  logic              clk = 1'b0;
  logic              rst, rdy, rst_c, en_i, rw_i, if_en_i;
  logic [ADDR_W-1:0] addr_i, if_addr_i, mem_a;
  logic [31:0]       data_i, data_o, if_data_o;
  logic [2:0]        width_i;
  logic              rdy_o, if_rdy_o, mem_wr;
  logic [7:0]        mem_din, mem_dout;

  mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rst_c(rst_c),
    .en_i(en_i), .rw_i(rw_i), .addr_i(addr_i), .data_i(data_i), .width_i(width_i),
    .rdy_o(rdy_o), .data_o(data_o),
    .if_en_i(if_en_i), .if_addr_i(if_addr_i), .if_rdy_o(if_rdy_o), .if_data_o(if_data_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM gated by the same rdy as the responder
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  logic [7:0]  exp_mem [0:4095];
  logic [39:0] wq [$];
  dexp_t       dq [$];
  logic [31:0] iq [$];
  int n_chk = 0, n_fail = 0, if_pulses = 0;

  initial begin
    logic        prev_r;
    logic [39:0] we;
    dexp_t       de;
    logic [31:0] ie;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rdy) begin
        if (mem_wr) begin
          n_chk++;
          if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL bus_write: got a=%h d=%h, required no write", mem_a, mem_dout);
          end else begin
            we = wq.pop_front();
            if ({mem_a, mem_dout} !== we) begin
              n_fail++;
              $display("FAIL bus_write: got a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, we[39:8], we[7:0]);
            end
          end
        end
        if (rdy_o) begin
          n_chk++;
          if (dq.size() == 0) begin
            n_fail++;
            $display("FAIL data_rdy: got unexpected rdy_o, required none");
          end else begin
            de = dq.pop_front();
            if (de.chk && data_o !== de.d) begin
              n_fail++;
              $display("FAIL data_o: got %h, required %h", data_o, de.d);
            end
          end
        end
        if (if_rdy_o) begin
          if_pulses++;
          n_chk++;
          if (iq.size() == 0) begin
            n_fail++;
            $display("FAIL fetch_rdy: got unexpected if_rdy_o, required none");
          end else begin
            ie = iq.pop_front();
            if (if_data_o !== ie) begin
              n_fail++;
              $display("FAIL if_data_o: got %h, required %h", if_data_o, ie);
            end
          end
        end
        if (rdy_o || if_rdy_o) begin
          n_chk++;
          if ((rdy_o && if_rdy_o) || prev_r) begin
            n_fail++;
            $display("FAIL pulse_shape: got rdy_o=%b if_rdy_o=%b prev=%b, required single lone pulse", rdy_o, if_rdy_o, prev_r);
          end
        end
        prev_r = rdy_o || if_rdy_o;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int n);
    logic [31:0] r, ak;
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      r[8*k +: 8] = exp_mem[ak[11:0]];
    end
    return r;
  endfunction

  task automatic push_data(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    int n;
    logic [31:0] ak;
    dexp_t e;
    n = (w >= 3'd4) ? 4 : int'(w);
    if (!rw) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        exp_mem[ak[11:0]] = d[8*k +: 8];
        wq.push_back({ak, d[8*k +: 8]});
      end
    end
    e.chk = rw || (n == 0);
    e.d   = rw ? mem_word(a, n) : 32'h0;
    dq.push_back(e);
  endtask

  task automatic drive_data(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    en_i = 1'b1; rw_i = rw; addr_i = a; data_i = d; width_i = w;
  endtask

  task automatic issue_data(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] w, output int t0);
    push_data(rw, a, d, w);
    @(posedge clk); #1;
    t0 = cyc;
    drive_data(rw, a, d, w);
  endtask

  // en_i stays high through the DONE cycle and drops in the following one
  task automatic wait_data(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy && rdy_o) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL data_timeout: got no rdy_o in 40 cycles, required rdy_o");
    end
    @(posedge clk); #1;
    en_i = 1'b0;
  endtask

  task automatic wait_fetch(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy && if_rdy_o) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL fetch_timeout: got no if_rdy_o in 40 cycles, required if_rdy_o");
    end
    @(posedge clk); #1;
    if_en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({rdy_o, if_rdy_o, mem_wr, data_o, if_data_o, mem_a, mem_dout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {rdy_o, if_rdy_o, mem_wr, data_o, if_data_o, mem_a, mem_dout});
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({rdy_o, if_rdy_o, mem_wr, data_o, if_data_o, mem_a, mem_dout} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: got %h, required 0", {rdy_o, if_rdy_o, mem_wr, data_o, if_data_o, mem_a, mem_dout});
      end
    end
  endtask

  task automatic test_store;
    int t0, lat;
    issue_data(1'b0, 32'h100, 32'hAABBCCDD, 3'd4, t0);
    wait_data(t0, lat);
    n_chk++;
    if (lat != 5) begin n_fail++; $display("FAIL store_latency: got %0d, required 5", lat); end
    n_chk++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL store_writes: got %0d pending, required 0", wq.size()); end
  endtask

  task automatic test_load;
    int t0, lat;
    issue_data(1'b0, 32'h200, 32'h80561234, 3'd4, t0); wait_data(t0, lat);
    issue_data(1'b0, 32'h300, 32'h44332211, 3'd4, t0); wait_data(t0, lat);
    issue_data(1'b1, 32'h200, 32'h0, 3'd2, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 4) begin n_fail++; $display("FAIL load2_latency: got %0d, required 4", lat); end
    issue_data(1'b1, 32'h203, 32'h0, 3'd1, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 3) begin n_fail++; $display("FAIL load1_latency: got %0d, required 3", lat); end
    issue_data(1'b1, 32'h300, 32'h0, 3'd3, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 5) begin n_fail++; $display("FAIL load3_latency: got %0d, required 5", lat); end
    issue_data(1'b1, 32'h200, 32'h0, 3'd7, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 6) begin n_fail++; $display("FAIL load_clip_latency: got %0d, required 6", lat); end
  endtask

  task automatic test_priority;
    int t0, lat, c1;
    push_data(1'b1, 32'h200, 32'h0, 3'd2);
    iq.push_back(mem_word(32'h300, 4));
    @(posedge clk); #1;
    t0 = cyc;
    drive_data(1'b1, 32'h200, 32'h0, 3'd2);
    if_en_i = 1'b1; if_addr_i = 32'h300;
    wait_data(t0, lat);
    c1 = t0 + lat;
    n_chk++;
    if (lat != 4) begin n_fail++; $display("FAIL priority_data_latency: got %0d, required 4", lat); end
    wait_fetch(t0, lat);
    n_chk++;
    if (t0 + lat - c1 != 7) begin n_fail++; $display("FAIL priority_fetch_gap: got %0d, required 7", t0 + lat - c1); end
  endtask

  task automatic test_flush;
    int t0, t1, lat, p0;
    p0 = if_pulses;
    @(posedge clk); #1;
    t0 = cyc; if_en_i = 1'b1; if_addr_i = 32'h300;
    @(posedge clk); #1;
    if_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_c = 1'b1;
    push_data(1'b0, 32'h110, 32'h0000005A, 3'd1);
    drive_data(1'b0, 32'h110, 32'h0000005A, 3'd1);
    @(posedge clk); #1;
    rst_c = 1'b0;
    wait_data(t0, lat);
    n_chk++;
    if (lat != 6) begin n_fail++; $display("FAIL flush_pending_store: got %0d, required 6", lat); end

    @(posedge clk); #1;
    t0 = cyc; if_en_i = 1'b1; if_addr_i = 32'h300;
    @(posedge clk); #1;
    if_en_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    t1 = cyc;
    push_data(1'b0, 32'h111, 32'h000000A5, 3'd1);
    drive_data(1'b0, 32'h111, 32'h000000A5, 3'd1);
    wait_data(t1, lat);
    n_chk++;
    if (lat != 2) begin n_fail++; $display("FAIL late_flush_idle: got %0d, required 2", lat); end

    issue_data(1'b0, 32'h120, 32'h0BADF00D, 3'd4, t0);
    repeat (3) @(posedge clk);
    #1;
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    wait_data(t0, lat);
    n_chk++;
    if (lat != 5) begin n_fail++; $display("FAIL flush_store_latency: got %0d, required 5", lat); end
    idle(10);
    n_chk++;
    if (if_pulses != p0) begin n_fail++; $display("FAIL flush_fetch_pulse: got %0d, required 0", if_pulses - p0); end
  endtask

  task automatic test_stall;
    int t0, lat;
    issue_data(1'b1, 32'h300, 32'h0, 3'd4, t0);
    repeat (2) @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_data(t0, lat);
    n_chk++;
    if (lat != 9) begin n_fail++; $display("FAIL stall_latency: got %0d, required 9", lat); end
    idle(4);
  endtask

  task automatic test_width0_wrap;
    int t0, lat;
    issue_data(1'b0, 32'h140, 32'hDEADBEEF, 3'd0, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 1) begin n_fail++; $display("FAIL store_w0_latency: got %0d, required 1", lat); end
    issue_data(1'b1, 32'h200, 32'h0, 3'd0, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 1) begin n_fail++; $display("FAIL load_w0_latency: got %0d, required 1", lat); end
    issue_data(1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 3'd2, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 3) begin n_fail++; $display("FAIL wrap_store_latency: got %0d, required 3", lat); end
    issue_data(1'b1, 32'hFFFFFFFF, 32'h0, 3'd2, t0); wait_data(t0, lat);
    n_chk++;
    if (lat != 4) begin n_fail++; $display("FAIL wrap_load_latency: got %0d, required 4", lat); end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rst_c = 1'b0;
    en_i = 1'b0; rw_i = 1'b0; addr_i = '0; data_i = '0; width_i = '0;
    if_en_i = 1'b0; if_addr_i = '0;
    test_reset;
    test_store;
    test_load;
    test_priority;
    test_flush;
    test_stall;
    test_width0_wrap;
    idle(8);
    n_chk++;
    if (wq.size() + dq.size() + iq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got w=%0d d=%0d i=%0d pending, required 0", wq.size(), dq.size(), iq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
